// File: rtl/keccak_pkg.sv
// Shared types and helpers for the keccak message sequencer.
package keccak_pkg;

  // Sequencer control states
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    PAD,
    WAIT_DIGEST,
    DONE
  } seq_state_t;

  // Keccak bitrate in bits for a given digest width
  function automatic int unsigned keccak_bitrate(input int unsigned outbits);
    return 1600 - 2 * outbits;
  endfunction

  // Only the four standard digest widths are supported by the core
  function automatic bit outbits_legal(input int unsigned outbits);
    return (outbits inside {224, 256, 384, 512}) && (keccak_bitrate(outbits) > 0);
  endfunction

endpackage

// File: rtl/keccak_msg_sequencer_if.sv
// Message stream input and digest output handshakes of the sequencer.
interface keccak_msg_sequencer_if #(
  parameter int OUTBITS = 512
);
  logic [31:0]        s_data;
  logic               s_valid;
  logic               s_last;
  logic [1:0]         s_bytes;
  logic               s_ready;
  logic [OUTBITS-1:0] m_digest;
  logic               m_valid;
  logic               m_ready;

  // Front-end side: offers words, consumes digests
  modport master (
    output s_data, s_valid, s_last, s_bytes, m_ready,
    input  s_ready, m_digest, m_valid
  );

  // Sequencer side: accepts words, produces digests
  modport slave (
    input  s_data, s_valid, s_last, s_bytes, m_ready,
    output s_ready, m_digest, m_valid
  );
endinterface

// File: rtl/keccak_seq_watchdog.sv
// Loadable down-counter; expired is high in the last enabled cycle of the budget.
module keccak_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_reg;

  // Load the full budget on entry, then count down once per enabled cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = en && (count_reg == CW'(1));
endmodule

// File: rtl/keccak_msg_sequencer.sv
// Drives one keccak core over whole messages: clear, feed, pad, collect digest.
module keccak_msg_sequencer
  import keccak_pkg::*;
#(
  parameter int unsigned OUTBITS        = 512,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  keccak_msg_sequencer_if.slave bus,
  output logic                 core_reset,
  output logic [31:0]          core_in,
  output logic                 core_in_ready,
  output logic                 core_is_last,
  output logic [1:0]           core_byte_num,
  input  logic                 core_buffer_full,
  input  logic [OUTBITS-1:0]   core_out,
  input  logic                 core_out_ready,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     msg_words
);

  generate
    if (!outbits_legal(OUTBITS)) begin : g_bad_outbits
      $error("keccak_msg_sequencer: OUTBITS must be 224, 256, 384 or 512");
    end
  endgenerate

  seq_state_t         state_reg;
  logic [OUTBITS-1:0] m_digest_reg;
  logic               m_valid_reg;
  logic               busy_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   msg_words_reg;

  logic in_feed;
  logic in_pad;
  logic s_fire;
  logic last_partial;
  logic pad_fire;
  logic to_wait;
  logic wd_expired;

  // Core strobes are combinational so a word never lands while the core is full;
  // reset masks everything so a word offered during reset is dropped.
  assign in_feed      = !reset && (state_reg == FEED);
  assign in_pad       = !reset && (state_reg == PAD);
  assign bus.s_ready  = in_feed && !core_buffer_full;
  assign s_fire       = bus.s_valid && bus.s_ready;
  assign last_partial = bus.s_last && (bus.s_bytes != 2'd0);
  assign pad_fire     = in_pad && !core_buffer_full;
  assign to_wait      = (s_fire && last_partial) || pad_fire;

  assign core_reset    = reset || (state_reg == CLEAR);
  assign core_in       = in_feed ? bus.s_data : 32'd0;
  assign core_in_ready = s_fire || pad_fire;
  assign core_is_last  = to_wait;
  assign core_byte_num = (s_fire && last_partial) ? bus.s_bytes : 2'd0;

  assign bus.m_digest = m_digest_reg;
  assign bus.m_valid  = m_valid_reg;
  assign busy         = busy_reg;
  assign err_timeout  = err_reg;
  assign msg_words    = msg_words_reg;

  keccak_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load   (to_wait),
    .en     (state_reg == WAIT_DIGEST),
    .expired(wd_expired)
  );

  // Message sequencing FSM with registered status and digest outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      m_digest_reg  <= '0;
      m_valid_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      msg_words_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.s_valid) begin
            state_reg     <= CLEAR;
            busy_reg      <= 1'b1;
            msg_words_reg <= '0;
          end
        end
        CLEAR: begin
          state_reg <= FEED;
        end
        FEED: begin
          if (s_fire) begin
            if (msg_words_reg != '1) begin
              msg_words_reg <= msg_words_reg + 1'b1;
            end
            if (bus.s_last) begin
              state_reg <= last_partial ? WAIT_DIGEST : PAD;
            end
          end
        end
        PAD: begin
          if (pad_fire) begin
            state_reg <= WAIT_DIGEST;
          end
        end
        WAIT_DIGEST: begin
          if (core_out_ready) begin
            m_digest_reg <= core_out;
            m_valid_reg  <= 1'b1;
            state_reg    <= DONE;
          end else if (wd_expired) begin
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        DONE: begin
          if (bus.m_ready) begin
            m_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          m_valid_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

endmodule
